// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared widths, command encodings and state encoding for the multi-cycle sequencer
package mc_ctrl_pkg;

  localparam int W_MEM_CMD = 2;
  localparam int W_PC_SRC  = 2;
  localparam int W_STATE   = 3;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP = 2'd0;

  typedef enum logic [W_STATE-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  // True when the decoder asks for a data memory access
  function automatic logic is_mem(input logic [W_MEM_CMD-1:0] cmd);
    return cmd != MEM_NOP;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - bounded wait counter that flags a memory handshake timeout
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // LAST is the count value seen during the TIMEOUT-th waiting cycle
  localparam int LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] r_cnt;

  // Count waiting cycles, saturating at LAST so a late ack never wraps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W'(LAST))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // A zero TIMEOUT means wait forever
  assign o_expired = (TIMEOUT != 0) && (r_cnt == W'(LAST));

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with commit gating
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int W_CNT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 ir_wen,
  input  logic                 dec_reg_wen,
  input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
  input  logic [W_PC_SRC-1:0]  dec_pc_src,
  input  logic                 dec_break,
  output logic                 dmem_req,
  output logic [W_MEM_CMD-1:0] dmem_cmd,
  input  logic                 dmem_ack,
  output logic                 reg_wen,
  output logic                 pc_wen,
  output logic [W_PC_SRC-1:0]  pc_src,
  output logic [W_STATE-1:0]   state,
  output logic                 halted,
  output logic                 fault,
  output logic [W_CNT-1:0]     retired
);

  state_e           r_state;
  logic [W_CNT-1:0] r_retired;
  logic             w_wait_clr;
  logic             w_wait_en;
  logic             w_expired;

  // FETCH and MEM are only ever entered from a non-waiting state, so holding
  // clear outside them zeroes the counter on every entry into a wait
  assign w_wait_clr = (r_state != S_FETCH) && (r_state != S_MEM);
  assign w_wait_en  = ((r_state == S_FETCH) && !imem_ack) ||
                      ((r_state == S_MEM)   && !dmem_ack);

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wait_clr),
    .i_en      (w_wait_en),
    .o_expired (w_expired)
  );

  // Sequencer state and retired-instruction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack)       r_state <= S_DECODE;
          else if (w_expired) r_state <= S_FAULT;
        end
        S_DECODE: begin
          r_state <= dec_break ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_state <= is_mem(dec_mem_cmd) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ack)       r_state <= S_WB;
          else if (w_expired) r_state <= S_FAULT;
        end
        S_WB: begin
          r_retired <= r_retired + W_CNT'(1);
          r_state   <= run ? S_FETCH : S_IDLE;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Requests and commit strobes decode from the state register so an async
  // reset clears them immediately; only ir_wen qualifies on the fetch ack so
  // the IR is loaded in the cycle the fetch data is valid
  assign imem_req = (r_state == S_FETCH);
  assign ir_wen   = (r_state == S_FETCH) && imem_ack;
  assign dmem_req = (r_state == S_MEM);
  assign dmem_cmd = (r_state == S_MEM) ? dec_mem_cmd : MEM_NOP;
  assign reg_wen  = (r_state == S_WB) && dec_reg_wen;
  assign pc_wen   = (r_state == S_WB);
  assign pc_src   = dec_pc_src;
  assign state    = r_state;
  assign halted   = (r_state == S_HALT) || (r_state == S_FAULT);
  assign fault    = (r_state == S_FAULT);
  assign retired  = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a cycle-table model
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int TO = 16;
  localparam int WC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, imem_ack, dmem_ack, dec_reg_wen, dec_break;
  logic [1:0] dec_mem_cmd, dec_pc_src;
  logic imem_req, ir_wen, dmem_req, reg_wen, pc_wen, halted, fault;
  logic [1:0] dmem_cmd, pc_src;
  logic [2:0] state;
  logic [WC-1:0] retired;

  logic run2, imem_ack2;
  logic imem_req2, ir_wen2, dmem_req2, reg_wen2, pc_wen2, halted2, fault2;
  logic [1:0] dmem_cmd2, pc_src2;
  logic [2:0] state2;
  logic [WC-1:0] retired2;

  mc_ctrl #(.TIMEOUT(TO), .W_CNT(WC)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_wen(ir_wen), .dec_reg_wen(dec_reg_wen), .dec_mem_cmd(dec_mem_cmd),
    .dec_pc_src(dec_pc_src), .dec_break(dec_break), .dmem_req(dmem_req),
    .dmem_cmd(dmem_cmd), .dmem_ack(dmem_ack), .reg_wen(reg_wen), .pc_wen(pc_wen),
    .pc_src(pc_src), .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  mc_ctrl #(.TIMEOUT(0), .W_CNT(WC)) dut_nto (
    .clk(clk), .rst(rst), .run(run2), .imem_req(imem_req2), .imem_ack(imem_ack2),
    .ir_wen(ir_wen2), .dec_reg_wen(1'b1), .dec_mem_cmd(2'd0),
    .dec_pc_src(2'd0), .dec_break(1'b0), .dmem_req(dmem_req2),
    .dmem_cmd(dmem_cmd2), .dmem_ack(1'b0), .reg_wen(reg_wen2), .pc_wen(pc_wen2),
    .pc_src(pc_src2), .state(state2), .halted(halted2), .fault(fault2), .retired(retired2)
  );

  typedef struct {
    logic run, ia, da, brk, rw;
    logic [1:0] cmd, ps;
    logic [2:0] st;
    logic ireq, irw, dreq, oreg, opw, hl, ft;
    logic [1:0] dcmd;
    logic [WC-1:0] ret;
  } ent_t;

  ent_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: 0 parked in IDLE, 1 running, 2 halted, 3 faulted
  int m_mode;
  logic [WC-1:0] m_ret;
  logic c_brk, c_rw;
  logic [1:0] c_cmd, c_ps;

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic mr(input int mid);
    if (mid == 2) return rb();
    return mid != 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One expected cycle: observable outputs follow directly from the state the
  // instruction should be in during that cycle
  task automatic push(input int st, input logic r, input logic ia, input logic da);
    ent_t e;
    e.run = r; e.ia = ia; e.da = da;
    e.brk = c_brk; e.cmd = c_cmd; e.rw = c_rw; e.ps = c_ps;
    e.st   = 3'(st);
    e.ireq = (st == 1);
    e.irw  = (st == 1) && ia;
    e.dreq = (st == 4);
    e.dcmd = (st == 4) ? c_cmd : 2'd0;
    e.oreg = (st == 5) && c_rw;
    e.opw  = (st == 5);
    e.hl   = (st >= 6);
    e.ft   = (st == 7);
    e.ret  = m_ret;
    q.push_back(e);
  endtask

  task automatic gen_instr(input int fw, input logic brk, input logic [1:0] cmd, input int mw,
                           input logic rw, input logic [1:0] ps, input logic run_wb,
                           input int gap, input int mid);
    c_brk = brk; c_cmd = cmd; c_rw = rw; c_ps = ps;
    if (m_mode >= 2) return;
    if (m_mode == 0) begin
      for (int i = 0; i < gap; i++) push(0, 1'b0, rb(), rb());
      push(0, 1'b1, rb(), rb());
    end
    if (fw >= TO) begin
      for (int i = 0; i < TO; i++) push(1, 1'b1, 1'b0, rb());
      m_mode = 3;
      return;
    end
    for (int i = 0; i < fw; i++) push(1, 1'b1, 1'b0, rb());
    push(1, 1'b1, 1'b1, rb());
    push(2, mr(mid), rb(), rb());
    if (brk) begin
      m_mode = 2;
      return;
    end
    push(3, mr(mid), rb(), rb());
    if (cmd != 2'd0) begin
      if (mw >= TO) begin
        for (int i = 0; i < TO; i++) push(4, mr(mid), rb(), 1'b0);
        m_mode = 3;
        return;
      end
      for (int i = 0; i < mw; i++) push(4, mr(mid), rb(), 1'b0);
      push(4, mr(mid), rb(), 1'b1);
    end
    push(5, run_wb, rb(), rb());
    m_ret = m_ret + 1'b1;
    m_mode = run_wb ? 1 : 0;
  endtask

  task automatic gen_stopped(input int n);
    for (int i = 0; i < n; i++) begin
      c_brk = rb(); c_rw = rb(); c_cmd = 2'($urandom_range(0, 3)); c_ps = 2'($urandom_range(0, 3));
      push((m_mode == 2) ? 6 : 7, rb(), rb(), rb());
    end
  endtask

  task automatic gen_park(input int n);
    for (int i = 0; i < n; i++) push(0, 1'b0, rb(), rb());
  endtask

  task automatic run_table();
    ent_t e;
    logic [17:0] act, exp;
    while (q.size() > 0) begin
      e = q.pop_front();
      run = e.run; imem_ack = e.ia; dmem_ack = e.da;
      dec_break = e.brk; dec_mem_cmd = e.cmd; dec_reg_wen = e.rw; dec_pc_src = e.ps;
      @(negedge clk);
      act = {state, imem_req, ir_wen, dmem_req, dmem_cmd, reg_wen, pc_wen, retired,
             halted, fault, pc_wen ? pc_src : 2'd0};
      exp = {e.st, e.ireq, e.irw, e.dreq, e.dcmd, e.oreg, e.opw, e.ret,
             e.hl, e.ft, e.opw ? e.ps : 2'd0};
      chk($sformatf("cycle%0d {st,ireq,irw,dreq,dcmd,rw,pw,ret,hl,ft,ps}", cyc),
          32'(act), 32'(exp));
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_break = 1'b0; dec_mem_cmd = 2'd0; dec_reg_wen = 1'b0; dec_pc_src = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0;
    m_ret = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic found;
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_break = 1'b0; dec_mem_cmd = 2'd0; dec_reg_wen = 1'b0; dec_pc_src = 2'd0;
    run2 = 1'b0; imem_ack2 = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'({imem_req, ir_wen, dmem_req, reg_wen, pc_wen, halted, fault}), 32'd0);
    chk("reset_dmem_cmd", 32'(dmem_cmd), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);

    do_reset();
    run2 = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("nto_still_fetch", 32'(state2), 32'd1);
    chk("nto_no_fault", 32'({fault2, halted2}), 32'd0);
    chk("nto_imem_req", 32'(imem_req2), 32'd1);
    chk("idle_without_run", 32'(state), 32'd0);
    run2 = 1'b0;

    // ADDI, LW with 3-cycle data wait, then BREAK
    s0 = q.size();
    gen_instr(0, 1'b0, 2'd0, 0, 1'b1, 2'd1, 1'b1, 0, 1);
    chk("model_addi_len", 32'(q.size() - s0), 32'd5);
    s0 = q.size();
    gen_instr(0, 1'b0, 2'd1, 3, 1'b1, 2'd0, 1'b1, 0, 1);
    chk("model_lw_len", 32'(q.size() - s0), 32'd8);
    gen_instr(1, 1'b1, 2'd0, 0, 1'b1, 2'd2, 1'b1, 0, 1);
    gen_stopped(6);
    run_table();
    chk("break_retired", 32'(retired), 32'd2);
    chk("break_halt", 32'({state, halted, fault}), 32'({3'd6, 1'b1, 1'b0}));

    // random instruction mix
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int fw, mw;
      logic [1:0] cmd;
      fw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) fw = TO - 1;
      mw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) mw = TO - 1;
      cmd = rb() ? 2'd0 : 2'($urandom_range(1, 3));
      gen_instr(fw, 1'b0, cmd, mw, rb(), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2), 2);
    end
    run_table();

    // fetch waits of 15 and data waits of 15 succeed, a 16-cycle fetch wait faults
    do_reset();
    gen_instr(TO - 1, 1'b0, 2'd2, TO - 1, 1'b0, 2'd3, 1'b1, 0, 1);
    gen_instr(TO, 1'b0, 2'd0, 0, 1'b1, 2'd0, 1'b1, 0, 1);
    gen_stopped(4);
    run_table();
    chk("timeout_fault", 32'({state, halted, fault}), 32'({3'd7, 1'b1, 1'b1}));
    chk("timeout_req_drop", 32'(imem_req), 32'd0);
    chk("timeout_retired", 32'(retired), 32'd1);

    // asynchronous reset in the middle of a data access
    do_reset();
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0; dec_mem_cmd = 2'd1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_mem", 32'(found), 32'd1);
    chk("mem_req_before_rst", 32'({dmem_req, dmem_cmd}), 32'({1'b1, 2'd1}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_dmem", 32'({dmem_req, dmem_cmd}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b0; imem_ack = 1'b0; dec_mem_cmd = 2'd0;
    m_mode = 0; m_ret = '0;
    gen_instr(0, 1'b0, 2'd0, 0, 1'b1, 2'd0, 1'b0, 1, 1);
    gen_park(2);
    run_table();
    chk("post_rst_retired", 32'(retired), 32'd1);

    // 17 ADDIs wrap the 4-bit counter; the last drops run during EXEC
    do_reset();
    for (int k = 0; k < 17; k++)
      gen_instr($urandom_range(0, 2), 1'b0, 2'd0, 0, 1'b1, 2'($urandom_range(0, 3)),
                k < 16, 0, (k == 16) ? 0 : 1);
    gen_park(3);
    run_table();
    chk("wrap_retired", 32'(retired), 32'd1);
    chk("wrap_parked", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
